// File: rtl/triangle_monitor_pkg.sv
// Shared types and constants for the triangle-wave monitor and its generator.
package triangle_pkg;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    UP      = 2'd2,
    DOWN    = 2'd3
  } tri_mon_state_t;

  // Direction encoding, identical on the generator side.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/triangle_monitor_if.sv
// Sample stream in, tracking status out. The source side is the master.
interface triangle_monitor_if #(
  parameter int N  = 8,
  parameter int CW = 16
);
  logic          ena;
  logic [N-1:0]  sample;
  logic          locked;
  logic          direction;
  logic [N-1:0]  expected;
  logic          peak;
  logic          trough;
  logic          error;
  logic [CW-1:0] error_count;
  logic [CW-1:0] period_count;

  modport master (
    output ena, sample,
    input  locked, direction, expected, peak, trough, error, error_count, period_count
  );

  modport slave (
    input  ena, sample,
    output locked, direction, expected, peak, trough, error, error_count, period_count
  );
endinterface

// File: rtl/triangle_monitor_adder_n.sv
// Plain N-bit adder; callers pass b = +1 or all-ones to get increment or decrement.
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum
);
  assign sum = a + b + N'(c_in);
endmodule

// File: rtl/triangle_monitor.sv
// Receive-side triangle-wave checker: locks onto phase/direction, predicts
// the next sample, and reports peaks, troughs, periods and mismatches.
module triangle_monitor
  import triangle_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input logic               clk,
  input logic               rst,
  triangle_monitor_if.slave bus
);

  localparam logic [N-1:0]  MAX    = '1;
  localparam logic [N-1:0]  ONE    = N'(1);
  localparam logic [N-1:0]  MAX_M1 = ~ONE;
  localparam logic [CW-1:0] CMAX   = '1;

  tri_mon_state_t state_q, state_d;
  logic [N-1:0]   last_q, last_d;
  logic           dir_q, dir_d;

  logic           locked_q, locked_d;
  logic [N-1:0]   expected_q, expected_d;
  logic           peak_q, peak_d;
  logic           trough_q, trough_d;
  logic           error_q, error_d;
  logic [CW-1:0]  err_cnt_q, err_cnt_d;
  logic [CW-1:0]  per_cnt_q, per_cnt_d;

  logic [N-1:0]   inc_sum, dec_sum, nxt_sum, nxt_b;
  logic [N-1:0]   pred, pred_next;
  logic           tracking, match;

  // last+1 and last-1 for acquisition and the current prediction
  adder_n #(.N(N)) u_inc (.a(last_q), .b(ONE), .c_in(1'b0), .sum(inc_sum));
  adder_n #(.N(N)) u_dec (.a(last_q), .b(MAX), .c_in(1'b0), .sum(dec_sum));
  // step from the post-update value, for the registered expected output
  adder_n #(.N(N)) u_nxt (.a(last_d), .b(nxt_b), .c_in(1'b0), .sum(nxt_sum));

  assign tracking = (state_q == UP) || (state_q == DOWN);

  // Endpoint-muxed prediction from the current state; never wraps.
  always_comb begin
    if (state_q == UP) pred = (last_q == MAX) ? MAX_M1 : inc_sum;
    else               pred = (last_q == '0)  ? ONE    : dec_sum;
    match = (bus.sample == pred);
  end

  // State register, last accepted sample and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= UNSYNC;
      last_q     <= '0;
      dir_q      <= DIR_UP;
      locked_q   <= 1'b0;
      expected_q <= '0;
      peak_q     <= 1'b0;
      trough_q   <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      per_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      dir_q      <= dir_d;
      locked_q   <= locked_d;
      expected_q <= expected_d;
      peak_q     <= peak_d;
      trough_q   <= trough_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
      per_cnt_q  <= per_cnt_d;
    end
  end

  // Next-state: acquisition, tracking, and direction flips at the endpoints
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = bus.ena ? bus.sample : last_q;
    if (bus.ena) begin
      unique case (state_q)
        UNSYNC: state_d = ACQUIRE;
        ACQUIRE: begin
          if (last_q != MAX && bus.sample == inc_sum) begin
            state_d = UP;
            dir_d   = DIR_UP;
          end else if (last_q != '0 && bus.sample == dec_sum) begin
            state_d = DOWN;
            dir_d   = DIR_DOWN;
          end
        end
        default: begin
          if (!match) begin
            state_d = ACQUIRE;
          end else begin
            // endpoints force the turn; otherwise the step sign decides,
            // which also handles a lock made right at an endpoint
            if (bus.sample == MAX)         state_d = DOWN;
            else if (bus.sample == '0)     state_d = UP;
            else if (bus.sample > last_q)  state_d = UP;
            else                           state_d = DOWN;
            dir_d = (state_d == UP) ? DIR_UP : DIR_DOWN;
          end
        end
      endcase
    end
  end

  // Output next values: event pulses, saturating counters, next prediction
  always_comb begin
    peak_d    = 1'b0;
    trough_d  = 1'b0;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    per_cnt_d = per_cnt_q;
    if (bus.ena && tracking) begin
      if (match) begin
        peak_d = (bus.sample == MAX);
        if (bus.sample == '0 && state_q == DOWN) begin
          trough_d = 1'b1;
          if (per_cnt_q != CMAX) per_cnt_d = per_cnt_q + CW'(1);
        end
      end else begin
        error_d = 1'b1;
        if (err_cnt_q != CMAX) err_cnt_d = err_cnt_q + CW'(1);
      end
    end
    locked_d = (state_d == UP) || (state_d == DOWN);
    nxt_b    = (state_d == UP) ? ONE : MAX;
    if (state_d == UP) pred_next = (last_d == MAX) ? MAX_M1 : nxt_sum;
    else               pred_next = (last_d == '0)  ? ONE    : nxt_sum;
    expected_d = locked_d ? pred_next : '0;
  end

  assign bus.locked       = locked_q;
  assign bus.direction    = dir_q;
  assign bus.expected     = expected_q;
  assign bus.peak         = peak_q;
  assign bus.trough       = trough_q;
  assign bus.error        = error_q;
  assign bus.error_count  = err_cnt_q;
  assign bus.period_count = per_cnt_q;

endmodule
